// File: rtl/spi_slave_link.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_link
// Description : SPI mode-0 slave front end. Oversamples sclk/mosi/ss_n in the
//               clk domain, deserialises MOSI bytes into an RX FIFO drained by
//               the backend (read/rd_ack), and serialises backend bytes queued
//               in a TX FIFO (write/wr_ack) onto MISO.
//               Optional macro SPI_LINK_ERR_CNT_EN adds a saturating
//               err_count output (dropped RX bytes + fill-byte loads).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_link #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic [7:0] rd_buffer,
    output logic       rd_empty,
    input  logic       read,
    output logic       rd_ack,
    input  logic [7:0] wr_buffer,
    input  logic       write,
    output logic       wr_ack,
    output logic       wr_full,
    output logic       rx_overrun,
    output logic       tx_underrun
`ifdef SPI_LINK_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Synchroniser / edge detector flops
    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_ss_s1, r_ss_s2, r_ss_s3;
    logic r_mosi_s1, r_mosi_s2;

    logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;

    // FSM and shifters
    state_t     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_tx_sr;
    logic [6:0] r_rx_sr;
    logic [7:0] w_rx_byte;
    logic       w_load, w_shift_out, w_rx_bit, w_rx_byte_done;

    // RX FIFO
    logic [7:0]         r_rx_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
    logic [c_CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic               w_rx_pop, w_rx_push, w_rx_drop;

    // TX FIFO
    logic [7:0]         r_tx_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
    logic [c_CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic               w_tx_pop, w_tx_push, w_fill;

    // Bring the SPI pins into clk; third stage gives the previous value for edges.
    // ss_n resets high so an idle bus produces no spurious select edge.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_ss_s1   <= 1'b1;
            r_ss_s2   <= 1'b1;
            r_ss_s3   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_ss_s1   <= ss_n;
            r_ss_s2   <= r_ss_s1;
            r_ss_s3   <= r_ss_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
    assign w_ss_rise   = r_ss_s2 & ~r_ss_s3;
    assign w_ss_fall   = ~r_ss_s2 & r_ss_s3;

    // FSM state register
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle shift/load strobes; deselect has priority over
    // a coincident sclk edge so a final fall at deselect never reloads.
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_shift_out    = 1'b0;
        w_rx_bit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load = 1'b1;
                w_state_nxt = w_ss_rise ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rx_bit    = w_sclk_rise;
                    w_load      = w_sclk_fall && (r_bit_cnt == 3'd0);
                    w_shift_out = w_sclk_fall && (r_bit_cnt != 3'd0);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_rx_byte      = {r_rx_sr, r_mosi_s2};
    assign w_rx_byte_done = w_rx_bit && (r_bit_cnt == 3'd7);
    assign w_tx_pop       = w_load && (r_tx_cnt != '0);
    assign w_fill         = w_load && (r_tx_cnt == '0);

    assign miso = (r_state != ST_IDLE) ? r_tx_sr[7] : 1'b0;

    // Bit counter, shift registers and sticky error flags
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_bit_cnt   <= 3'd0;
            r_tx_sr     <= 8'h00;
            r_rx_sr     <= 7'h00;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (r_state == ST_LOAD || w_ss_rise) begin
                r_bit_cnt <= 3'd0;
                r_rx_sr   <= 7'h00;
            end else if (w_rx_bit) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_rx_sr   <= w_rx_byte[6:0];
            end
            if (w_load) begin
                r_tx_sr <= w_tx_pop ? r_tx_mem[r_tx_rd_ptr] : FILL_BYTE;
            end else if (w_shift_out) begin
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
            end
            if (w_rx_drop) begin
                rx_overrun <= 1'b1;
            end
            if (w_fill) begin
                tx_underrun <= 1'b1;
            end
        end
    end

    // RX FIFO control: a pop in the same cycle makes room for a push when full
    assign w_rx_pop  = read && !rd_empty && !rd_ack;
    assign w_rx_push = w_rx_byte_done && ((r_rx_cnt != c_DEPTH) || w_rx_pop);
    assign w_rx_drop = w_rx_byte_done && !w_rx_push;

    always_comb begin
        w_rx_cnt_nxt = r_rx_cnt;
        if (w_rx_push && !w_rx_pop) begin
            w_rx_cnt_nxt = r_rx_cnt + c_CNT_ONE;
        end else if (!w_rx_push && w_rx_pop) begin
            w_rx_cnt_nxt = r_rx_cnt - c_CNT_ONE;
        end
    end

    // RX pointers, count, empty flag and the acknowledged read data
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_cnt    <= '0;
            rd_empty    <= 1'b1;
            rd_ack      <= 1'b0;
            rd_buffer   <= 8'h00;
        end else begin
            r_rx_cnt <= w_rx_cnt_nxt;
            rd_empty <= (w_rx_cnt_nxt == '0);
            rd_ack   <= w_rx_pop;
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + c_PTR_ONE;
            end
            if (w_rx_pop) begin
                rd_buffer   <= r_rx_mem[r_rx_rd_ptr];
                r_rx_rd_ptr <= r_rx_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // RX storage (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= w_rx_byte;
        end
    end

    // TX FIFO control: same-cycle pop also lets a push into a full FIFO
    assign w_tx_push = write && !wr_ack && (!wr_full || w_tx_pop);

    always_comb begin
        w_tx_cnt_nxt = r_tx_cnt;
        if (w_tx_push && !w_tx_pop) begin
            w_tx_cnt_nxt = r_tx_cnt + c_CNT_ONE;
        end else if (!w_tx_push && w_tx_pop) begin
            w_tx_cnt_nxt = r_tx_cnt - c_CNT_ONE;
        end
    end

    // TX pointers, count, full flag and the write acknowledge
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_cnt    <= '0;
            wr_full     <= 1'b0;
            wr_ack      <= 1'b0;
        end else begin
            r_tx_cnt <= w_tx_cnt_nxt;
            wr_full  <= (w_tx_cnt_nxt == c_DEPTH);
            wr_ack   <= w_tx_push;
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + c_PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // TX storage
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= wr_buffer;
        end
    end

`ifdef SPI_LINK_ERR_CNT_EN
    logic [1:0] w_err_inc;
    logic [8:0] w_err_sum;

    assign w_err_inc = {1'b0, w_rx_drop} + {1'b0, w_fill};
    assign w_err_sum = {1'b0, err_count} + {7'b0, w_err_inc};

    // Saturating error counter: drops and fill loads, both may land together
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            err_count <= 8'h00;
        end else begin
            err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_link
// Description : Self-checking bench for spi_slave_link. A byte-level model
//               (TX/RX queues plus sticky flags) predicts MISO bytes, RX data
//               and status for directed and random SPI transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_link;

    localparam int         c_DEPTH = 8;
    localparam logic [7:0] c_FILL  = 8'hFF;
    localparam int         c_HALF  = 8;   // clk cycles per sclk half period

    logic       clk = 1'b0;
    logic       rst_L;
    logic       sclk, mosi, ss_n, miso;
    logic [7:0] rd_buffer;
    logic       rd_empty, read, rd_ack;
    logic [7:0] wr_buffer;
    logic       write, wr_ack, wr_full;
    logic       rx_overrun, tx_underrun;
`ifdef SPI_LINK_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    spi_slave_link #(.FIFO_DEPTH(c_DEPTH), .FILL_BYTE(c_FILL)) u_dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss_n       (ss_n),
        .miso       (miso),
        .rd_buffer  (rd_buffer),
        .rd_empty   (rd_empty),
        .read       (read),
        .rd_ack     (rd_ack),
        .wr_buffer  (wr_buffer),
        .write      (write),
        .wr_ack     (wr_ack),
        .wr_full    (wr_full),
        .rx_overrun (rx_overrun),
        .tx_underrun(tx_underrun)
`ifdef SPI_LINK_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [7:0] m_tx_q[$];
    logic [7:0] m_rx_q[$];
    logic       m_rx_ovr = 1'b0;
    logic       m_tx_und = 1'b0;
    int         m_err    = 0;

    logic [7:0] mo_bytes [16];
    logic [7:0] mi_bytes [16];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic be_write(input logic [7:0] b);
        bit seen = 0;
        if (m_tx_q.size() >= c_DEPTH) return;
        wr_buffer = b;
        write     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_ack) begin
                seen = 1;
                break;
            end
        end
        write = 1'b0;
        check_val("wr_ack_seen", 32'(seen), 1);
        m_tx_q.push_back(b);
    endtask

    task automatic be_read();
        bit seen = 0;
        logic [7:0] exp;
        exp  = m_rx_q.pop_front();
        read = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                seen = 1;
                break;
            end
        end
        read = 1'b0;
        check_val("rd_ack_seen", 32'(seen), 1);
        check_val("rd_data", {24'h0, rd_buffer}, {24'h0, exp});
    endtask

    // Master transfer of nbits bits from mo_bytes; the last fall coincides with deselect
    task automatic spi_xfer(input int nbits);
        int nstart, ndone;
        logic [7:0] exp_b;
        for (int k = 0; k < 16; k++) mi_bytes[k] = 8'h00;
        ss_n = 1'b0;
        wait_clk(c_HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo_bytes[i/8][7 - (i % 8)];
            wait_clk(c_HALF);
            mi_bytes[i/8][7 - (i % 8)] = miso;
            sclk = 1'b1;
            wait_clk(c_HALF);
            sclk = 1'b0;
            if (i == nbits - 1) ss_n = 1'b1;
        end
        wait_clk(12);
        // Model: one TX load per started byte, one RX push per complete byte
        nstart = (nbits + 7) / 8;
        ndone  = nbits / 8;
        for (int k = 0; k < nstart; k++) begin
            if (m_tx_q.size() > 0) begin
                exp_b = m_tx_q.pop_front();
            end else begin
                exp_b = c_FILL;
                m_tx_und = 1'b1;
                m_err = (m_err < 255) ? m_err + 1 : 255;
            end
            if (k < ndone) check_val("miso_byte", {24'h0, mi_bytes[k]}, {24'h0, exp_b});
        end
        for (int k = 0; k < ndone; k++) begin
            if (m_rx_q.size() < c_DEPTH) begin
                m_rx_q.push_back(mo_bytes[k]);
            end else begin
                m_rx_ovr = 1'b1;
                m_err = (m_err < 255) ? m_err + 1 : 255;
            end
        end
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_rd_empty"}, 32'(rd_empty), 32'(m_rx_q.size() == 0));
        check_val({tag, "_wr_full"}, 32'(wr_full), 32'(m_tx_q.size() == c_DEPTH));
        check_val({tag, "_rx_overrun"}, 32'(rx_overrun), 32'(m_rx_ovr));
        check_val({tag, "_tx_underrun"}, 32'(tx_underrun), 32'(m_tx_und));
`ifdef SPI_LINK_ERR_CNT_EN
        check_val({tag, "_err_count"}, {24'h0, err_count}, 32'(m_err));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_miso"}, 32'(miso), 0);
        check_val({tag, "_rd_buffer"}, {24'h0, rd_buffer}, 0);
        check_val({tag, "_rd_ack"}, 32'(rd_ack), 0);
        check_val({tag, "_wr_ack"}, 32'(wr_ack), 0);
        check_val({tag, "_rd_empty"}, 32'(rd_empty), 1);
        check_val({tag, "_wr_full"}, 32'(wr_full), 0);
        check_val({tag, "_rx_overrun"}, 32'(rx_overrun), 0);
        check_val({tag, "_tx_underrun"}, 32'(tx_underrun), 0);
`ifdef SPI_LINK_ERR_CNT_EN
        check_val({tag, "_err_count"}, {24'h0, err_count}, 0);
`endif
    endtask

    initial begin
        int acks, b2b, nb, nbits;
        logic prev_ack;
        rst_L = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        read = 1'b0; write = 1'b0; wr_buffer = 8'h00;
        wait_clk(4);
        check_reset_outputs("reset");
        rst_L = 1'b1;
        wait_clk(4);

        // Backend preloads TX; master sends A5,3C and receives 81,7E
        be_write(8'h81);
        be_write(8'h7E);
        mo_bytes[0] = 8'hA5; mo_bytes[1] = 8'h3C;
        spi_xfer(16);
        check_status("two_bytes");
        be_read();
        be_read();
        check_status("two_bytes_drained");

        // One queued TX byte, three clocked bytes -> 55, FF, FF
        be_write(8'h55);
        for (int k = 0; k < 3; k++) mo_bytes[k] = 8'(k + 1);
        spi_xfer(24);
        check_status("underrun");
        while (m_rx_q.size() > 0) be_read();

        // Full TX FIFO, then FIFO_DEPTH+1 RX bytes without reads
        for (int k = 0; k < c_DEPTH; k++) be_write(8'(8'h10 + k));
        check_status("tx_full");
        for (int k = 0; k <= c_DEPTH; k++) mo_bytes[k] = 8'(8'hC0 + k);
        spi_xfer(8 * (c_DEPTH + 1));
        check_status("overrun");
        while (m_rx_q.size() > 0) be_read();
        check_status("overrun_drained");

        // read held high with two bytes queued
        mo_bytes[0] = 8'h6B; mo_bytes[1] = 8'h94;
        spi_xfer(16);
        acks = 0; b2b = 0; prev_ack = 1'b0;
        read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                acks++;
                if (prev_ack) b2b++;
                if (m_rx_q.size() > 0)
                    check_val("held_rd_data", {24'h0, rd_buffer}, {24'h0, m_rx_q.pop_front()});
            end
            prev_ack = rd_ack;
        end
        read = 1'b0;
        check_val("held_ack_count", 32'(acks), 2);
        check_val("held_back_to_back", 32'(b2b), 0);
        check_status("held_read");

        // Aborted partial byte followed by a full one
        mo_bytes[0] = 8'hF0;
        spi_xfer(5);
        mo_bytes[0] = 8'h12;
        spi_xfer(8);
        check_val("partial_rx_count", 32'(m_rx_q.size()), 1);
        be_read();
        check_status("partial");

        // Randomised traffic
        for (int it = 0; it < 25; it++) begin
            nb = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) be_write(8'($urandom));
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) mo_bytes[k] = 8'($urandom);
            nbits = nb * 8;
            if ($urandom_range(0, 3) == 0) nbits = nbits - $urandom_range(1, 7);
            spi_xfer(nbits);
            check_status("rand");
            nb = $urandom_range(0, m_rx_q.size());
            for (int k = 0; k < nb; k++) be_read();
        end

        // Reset in the middle of a byte with TX data queued
        be_write(8'h3A);
        ss_n = 1'b0;
        wait_clk(c_HALF);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            wait_clk(c_HALF);
            sclk = 1'b1;
            wait_clk(c_HALF);
            sclk = 1'b0;
        end
        sclk = 1'b1;
        wait_clk(2);
        rst_L = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        wait_clk(4);
        rst_L = 1'b1;
        m_tx_q.delete(); m_rx_q.delete();
        m_rx_ovr = 1'b0; m_tx_und = 1'b0; m_err = 0;
        wait_clk(4);
        check_reset_outputs("after_reset");
        // Flushed TX must yield the fill byte
        mo_bytes[0] = 8'h5C;
        spi_xfer(8);
        check_status("post_reset_xfer");
        be_read();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit
    initial begin
        #20ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
